// File: rtl/memory_stage_ctrl.sv
// Memory-stage controller: data-memory access, stack pointer, and multi-word PC/flag stack sequencing.
// Single-word ops take one cycle; CALL/RET stall 1 cycle, INT/RTI stall 2; inputs ignored mid-sequence.
module memory_stage_ctrl #(
  parameter int                ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_push,
  input  logic              mem_pop,
  input  logic [2:0]        pc_op,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       write_data,
  input  logic [31:0]       pc_plus_one,
  input  logic [2:0]        flags_in,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic [15:0]       mem_data_out,
  output logic              stall,
  output logic [31:0]       pc_from_mem,
  output logic              pc_load,
  output logic [2:0]        flags_restored,
  output logic              flags_restore,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  typedef enum logic {S_IDLE, S_SEQ} state_t;
  typedef enum logic [1:0] {OP_CALL, OP_RET, OP_INT, OP_RTI} op_t;

  localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       pc_q, pc_d;
  logic [2:0]        flags_q, flags_d;
  logic [15:0]       lo_q, lo_d;
  logic [15:0]       hi_q, hi_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              err_q, err_d;
  logic [15:0]       dout_q, dout_d;
  logic [31:0]       pcm_q, pcm_d;
  logic              pc_load_q, pc_load_d;
  logic [2:0]        flr_q, flr_d;
  logic              flrs_q, flrs_d;

  logic              req_vld;
  op_t               req_op;
  logic              seq_word;
  op_t               cur_op;
  logic [1:0]        cur_idx;
  logic [31:0]       cur_pc;
  logic [2:0]        cur_flags;
  logic [1:0]        last_idx;
  logic              do_push;
  logic              do_pop;
  logic [15:0]       push_dat;
  logic              unused_alu_bits;

  assign unused_alu_bits = ^alu_result;

  always_comb begin
    req_vld = 1'b1;
    req_op  = OP_CALL;
    case (pc_op)
      3'b001:  req_op = OP_CALL;
      3'b010:  req_op = OP_RET;
      3'b011:  req_op = OP_INT;
      3'b100:  req_op = OP_RTI;
      default: req_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    sp_d      = sp_q;
    err_d     = err_q;
    dout_d    = dout_q;
    pcm_d     = pcm_q;
    pc_load_d = 1'b0;
    flr_d     = flr_q;
    flrs_d    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    stall     = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    push_dat  = '0;

    // Word 0 of a sequence issues straight from the inputs; later words use the latched copy.
    seq_word  = (state_q == S_SEQ) || req_vld;
    cur_op    = (state_q == S_SEQ) ? op_q : req_op;
    cur_idx   = (state_q == S_SEQ) ? idx_q : 2'd0;
    cur_pc    = (state_q == S_SEQ) ? pc_q : pc_plus_one;
    cur_flags = (state_q == S_SEQ) ? flags_q : flags_in;
    last_idx  = (cur_op == OP_INT || cur_op == OP_RTI) ? 2'd2 : 2'd1;

    if (seq_word) begin
      stall   = (cur_idx != last_idx);
      op_d    = cur_op;
      pc_d    = cur_pc;
      flags_d = cur_flags;
      if (cur_idx == last_idx) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_SEQ;
        idx_d   = cur_idx + 2'd1;
      end
      case (cur_op)
        OP_CALL: begin
          do_push  = 1'b1;
          push_dat = (cur_idx == 2'd0) ? cur_pc[31:16] : cur_pc[15:0];
        end
        OP_INT: begin
          do_push = 1'b1;
          case (cur_idx)
            2'd0:    push_dat = {13'b0, cur_flags};
            2'd1:    push_dat = cur_pc[31:16];
            default: push_dat = cur_pc[15:0];
          endcase
        end
        default: begin
          do_pop = 1'b1;
          case (cur_idx)
            2'd0: lo_d = mem_rdata;
            2'd1: begin
              if (cur_op == OP_RET) begin
                pcm_d     = {mem_rdata, lo_q};
                pc_load_d = 1'b1;
              end else begin
                hi_d = mem_rdata;
              end
            end
            default: begin
              pcm_d     = {hi_q, lo_q};
              pc_load_d = 1'b1;
              flr_d     = mem_rdata[2:0];
              flrs_d    = 1'b1;
            end
          endcase
        end
      endcase
    end else if (mem_push) begin
      do_push  = 1'b1;
      push_dat = write_data;
    end else if (mem_pop) begin
      do_pop = 1'b1;
      dout_d = mem_rdata;
    end else if (mem_write) begin
      mem_addr  = alu_result[ADDR_W-1:0];
      mem_we    = 1'b1;
      mem_wdata = write_data;
    end else if (mem_read) begin
      mem_addr = alu_result[ADDR_W-1:0];
      dout_d   = mem_rdata;
    end

    // Out-of-range stack accesses still go through and wrap; only the sticky flag records them.
    if (do_push) begin
      mem_addr  = sp_q;
      mem_we    = 1'b1;
      mem_wdata = push_dat;
      sp_d      = sp_q - SP_ONE;
      if (sp_q == '0) err_d = 1'b1;
    end
    if (do_pop) begin
      mem_addr = sp_q + SP_ONE;
      sp_d     = sp_q + SP_ONE;
      if (sp_q == SP_INIT) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_CALL;
      idx_q     <= 2'd0;
      pc_q      <= '0;
      flags_q   <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      sp_q      <= SP_INIT;
      err_q     <= 1'b0;
      dout_q    <= '0;
      pcm_q     <= '0;
      pc_load_q <= 1'b0;
      flr_q     <= '0;
      flrs_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
      pcm_q     <= pcm_d;
      pc_load_q <= pc_load_d;
      flr_q     <= flr_d;
      flrs_q    <= flrs_d;
    end
  end

  assign mem_data_out   = dout_q;
  assign pc_from_mem    = pcm_q;
  assign pc_load        = pc_load_q;
  assign flags_restored = flr_q;
  assign flags_restore  = flrs_q;
  assign sp             = sp_q;
  assign stack_err      = err_q;

endmodule

// File: tb/tb_memory_stage_ctrl.sv
// Directed bench for memory_stage_ctrl with a 4K x 16 data memory model.
module tb_memory_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_push = 1'b0;
  logic        mem_pop = 1'b0;
  logic [2:0]  pc_op = 3'd0;
  logic [15:0] alu_result = 16'h0;
  logic [15:0] write_data = 16'h0;
  logic [31:0] pc_plus_one = 32'h0;
  logic [2:0]  flags_in = 3'd0;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_data_out;
  logic        stall;
  logic [31:0] pc_from_mem;
  logic        pc_load;
  logic [2:0]  flags_restored;
  logic        flags_restore;
  logic [11:0] sp;
  logic        stack_err;

  logic [15:0] mem [0:4095];
  int checks = 0;
  int errors = 0;

  memory_stage_ctrl #(.ADDR_W(12), .SP_INIT(12'hFFF)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_push(mem_push), .mem_pop(mem_pop), .pc_op(pc_op), .alu_result(alu_result),
    .write_data(write_data), .pc_plus_one(pc_plus_one), .flags_in(flags_in),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_data_out(mem_data_out), .stall(stall), .pc_from_mem(pc_from_mem),
    .pc_load(pc_load), .flags_restored(flags_restored), .flags_restore(flags_restore),
    .sp(sp), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; mem_push = 1'b0; mem_pop = 1'b0; pc_op = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_sp", 32'(sp), 32'hFFF);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_dout", 32'(mem_data_out), 32'h0);
    chk("rst_pcload", 32'(pc_load), 32'h0);
    chk("rst_pcm", pc_from_mem, 32'h0);
    chk("rst_flr", 32'(flags_restored), 32'h0);
    chk("rst_flrs", 32'(flags_restore), 32'h0);
    chk("rst_err", 32'(stack_err), 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;

    // PUSH 0xBEEF then POP
    mem_push = 1'b1; write_data = 16'hBEEF; #1;
    chk("push_we", 32'(mem_we), 32'h1);
    chk("push_addr", 32'(mem_addr), 32'hFFF);
    chk("push_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("push_stall", 32'(stall), 32'h0);
    next_cycle(); idle_inputs();
    chk("push_sp", 32'(sp), 32'hFFE);
    chk("push_mem", 32'(mem[12'hFFF]), 32'hBEEF);
    mem_pop = 1'b1; #1;
    chk("pop_addr", 32'(mem_addr), 32'hFFF);
    chk("pop_we", 32'(mem_we), 32'h0);
    next_cycle(); idle_inputs();
    chk("pop_dout", 32'(mem_data_out), 32'hBEEF);
    chk("pop_sp", 32'(sp), 32'hFFF);
    chk("pop_err", 32'(stack_err), 32'h0);

    // CALL 0x0001_2345; pc_op held through the sequence must be ignored
    pc_op = 3'b001; pc_plus_one = 32'h0001_2345; #1;
    chk("call0_stall", 32'(stall), 32'h1);
    chk("call0_addr", 32'(mem_addr), 32'hFFF);
    chk("call0_wdata", 32'(mem_wdata), 32'h0001);
    next_cycle();
    chk("call1_stall", 32'(stall), 32'h0);
    chk("call1_addr", 32'(mem_addr), 32'hFFE);
    chk("call1_wdata", 32'(mem_wdata), 32'h2345);
    chk("call1_we", 32'(mem_we), 32'h1);
    next_cycle(); idle_inputs(); #1;
    chk("call_sp", 32'(sp), 32'hFFD);
    chk("call_mem_hi", 32'(mem[12'hFFF]), 32'h0001);
    chk("call_mem_lo", 32'(mem[12'hFFE]), 32'h2345);
    chk("call_idle_we", 32'(mem_we), 32'h0);

    // RET
    pc_op = 3'b010; #1;
    chk("ret0_stall", 32'(stall), 32'h1);
    chk("ret0_addr", 32'(mem_addr), 32'hFFE);
    next_cycle(); idle_inputs();
    chk("ret1_stall", 32'(stall), 32'h0);
    chk("ret1_addr", 32'(mem_addr), 32'hFFF);
    chk("ret1_pcload", 32'(pc_load), 32'h0);
    next_cycle();
    chk("ret_pcload", 32'(pc_load), 32'h1);
    chk("ret_pcm", pc_from_mem, 32'h0001_2345);
    chk("ret_sp", 32'(sp), 32'hFFF);
    next_cycle();
    chk("ret_pcload_off", 32'(pc_load), 32'h0);
    chk("ret_pcm_hold", pc_from_mem, 32'h0001_2345);

    // INT flags=101, PC=0x40; inputs change after word 0 and must not matter
    pc_op = 3'b011; flags_in = 3'b101; pc_plus_one = 32'h0000_0040; #1;
    chk("int0_stall", 32'(stall), 32'h1);
    chk("int0_addr", 32'(mem_addr), 32'hFFF);
    chk("int0_wdata", 32'(mem_wdata), 32'h0005);
    next_cycle(); idle_inputs(); flags_in = 3'b000; pc_plus_one = 32'hDEAD_BEEF; #1;
    chk("int1_stall", 32'(stall), 32'h1);
    chk("int1_addr", 32'(mem_addr), 32'hFFE);
    chk("int1_wdata", 32'(mem_wdata), 32'h0000);
    next_cycle();
    chk("int2_stall", 32'(stall), 32'h0);
    chk("int2_addr", 32'(mem_addr), 32'hFFD);
    chk("int2_wdata", 32'(mem_wdata), 32'h0040);
    next_cycle();
    chk("int_sp", 32'(sp), 32'hFFC);

    // RTI
    pc_op = 3'b100; #1;
    chk("rti0_stall", 32'(stall), 32'h1);
    chk("rti0_addr", 32'(mem_addr), 32'hFFD);
    next_cycle(); idle_inputs();
    chk("rti1_stall", 32'(stall), 32'h1);
    chk("rti1_addr", 32'(mem_addr), 32'hFFE);
    next_cycle();
    chk("rti2_stall", 32'(stall), 32'h0);
    chk("rti2_addr", 32'(mem_addr), 32'hFFF);
    chk("rti2_pcload", 32'(pc_load), 32'h0);
    next_cycle();
    chk("rti_pcload", 32'(pc_load), 32'h1);
    chk("rti_flrs", 32'(flags_restore), 32'h1);
    chk("rti_pcm", pc_from_mem, 32'h0000_0040);
    chk("rti_flr", 32'(flags_restored), 32'h5);
    chk("rti_sp", 32'(sp), 32'hFFF);
    next_cycle();
    chk("rti_pcload_off", 32'(pc_load), 32'h0);
    chk("rti_flrs_off", 32'(flags_restore), 32'h0);
    chk("rti_flr_hold", 32'(flags_restored), 32'h5);

    // STR then LDR back to back; upper alu_result bits are ignored
    mem_write = 1'b1; alu_result = 16'h0010; write_data = 16'h1234; #1;
    chk("str_we", 32'(mem_we), 32'h1);
    chk("str_addr", 32'(mem_addr), 32'h010);
    chk("str_wdata", 32'(mem_wdata), 32'h1234);
    chk("str_stall", 32'(stall), 32'h0);
    next_cycle(); idle_inputs();
    mem_read = 1'b1; alu_result = 16'hF010; #1;
    chk("ldr_addr", 32'(mem_addr), 32'h010);
    chk("ldr_we", 32'(mem_we), 32'h0);
    chk("ldr_stall", 32'(stall), 32'h0);
    next_cycle(); idle_inputs();
    chk("ldr_dout", 32'(mem_data_out), 32'h1234);
    chk("ldr_sp", 32'(sp), 32'hFFF);

    // POP on empty stack underflows and wraps; PUSH keeps the sticky flag
    mem_pop = 1'b1; #1;
    chk("uf_addr", 32'(mem_addr), 32'h000);
    next_cycle(); idle_inputs();
    chk("uf_err", 32'(stack_err), 32'h1);
    chk("uf_sp", 32'(sp), 32'h000);
    mem_push = 1'b1; write_data = 16'h5555; #1;
    chk("uf_push_addr", 32'(mem_addr), 32'h000);
    next_cycle(); idle_inputs();
    chk("uf_push_sp", 32'(sp), 32'hFFF);
    chk("uf_push_err", 32'(stack_err), 32'h1);

    // INT to fill the stack, then RTI aborted by reset in its second cycle
    pc_op = 3'b011; flags_in = 3'b011; pc_plus_one = 32'h0000_0777;
    next_cycle(); idle_inputs();
    next_cycle();
    next_cycle();
    chk("int2_setup_sp", 32'(sp), 32'hFFC);
    pc_op = 3'b100;
    next_cycle(); idle_inputs();
    reset = 1'b0; #1;
    chk("abort_sp", 32'(sp), 32'hFFF);
    chk("abort_stall", 32'(stall), 32'h0);
    chk("abort_we", 32'(mem_we), 32'h0);
    chk("abort_addr", 32'(mem_addr), 32'h000);
    chk("abort_err", 32'(stack_err), 32'h0);
    chk("abort_pcm", pc_from_mem, 32'h0);
    chk("abort_flr", 32'(flags_restored), 32'h0);
    chk("abort_dout", 32'(mem_data_out), 32'h0);
    next_cycle();
    chk("abort_pcload", 32'(pc_load), 32'h0);
    chk("abort_flrs", 32'(flags_restore), 32'h0);
    reset = 1'b1;
    next_cycle();
    chk("abort_post_pcload", 32'(pc_load), 32'h0);
    chk("abort_post_sp", 32'(sp), 32'hFFF);

    // CALL then RET after the aborted sequence
    pc_op = 3'b001; pc_plus_one = 32'h00AB_CDEF; #1;
    chk("call2_wdata0", 32'(mem_wdata), 32'h00AB);
    next_cycle(); idle_inputs();
    chk("call2_wdata1", 32'(mem_wdata), 32'hCDEF);
    next_cycle();
    pc_op = 3'b010; #1;
    chk("ret2_stall", 32'(stall), 32'h1);
    next_cycle(); idle_inputs();
    next_cycle();
    chk("ret2_pcload", 32'(pc_load), 32'h1);
    chk("ret2_pcm", pc_from_mem, 32'h00AB_CDEF);
    chk("ret2_sp", 32'(sp), 32'hFFF);
    chk("ret2_flrs", 32'(flags_restore), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
